mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Arbiter and byte-serial port between the core and the single 8-bit external RAM/IO bus.
//  Two clients: instruction fetch (IF, read-only) and the MEM stage (LOAD/STORE).
//  The owner holds the bus for a whole multi-byte transaction; the block reports the owner on if_or_mem.
//  Stores to the IO window are throttled by io_buffer_full.
// PARAMETERS
//  ADDR_W      32       width of all byte addresses
//  IO_SEL_HI   17       high bit of the IO-window select field
//  IO_SEL_LO   16       low bit of the IO-window select field; the IO window is where addr[HI:LO]==2'b11
// PORTS
//  clk             in   1   system clock
//  rst             in   1   synchronous, active-high reset (rst == `RstEnable)
//  if_request      in   1   IF wants to read bytes
//  if_addr         in   32  IF byte address
//  if_data_o       out  8   read byte returned to IF
//  mem_request     in   2   from MEM: 00 none, 01 LOAD, 10 STORE
//  mem_addr        in   32  MEM byte address
//  mem_data_i      in   8   MEM store byte (MEM drives it as mem_ctrl_data_o)
//  mem_data_o      out  8   read byte returned to MEM (MEM samples it as mem_ctrl_data_i)
//  if_or_mem       out  2   current owner: 00 none, 01 IF, 10 MEM
//  if_stall_request out 1   IF is requesting but is not the owner
//  io_buffer_full  in   1   the external IO write buffer cannot accept a byte
//  ram_din         in   8   byte from the RAM; valid 1 cycle after its address
//  ram_dout        out  8   byte to the RAM
//  ram_a           out  32  RAM address
//  ram_wr          out  1   1 = write, 0 = read
// BEHAVIOUR
//  FSM owner_q, registered: IDLE, IF, MEM, SWITCH. Reset puts it in IDLE; if_or_mem=00, ram_wr=0,
//   ram_a=0, ram_dout=0, if_stall_request=0, data outputs=0.
//  IDLE: if mem_request!=00, go to MEM, even if IF is also requesting (MEM has priority).
//   Otherwise, if if_request=1, go to IF. Otherwise stay in IDLE.
//  IF: stay while if_request=1; when it drops, go to IDLE.
//   A MEM request arriving during the IF transaction waits; there is no preemption.
//  MEM: stay while mem_request!=00. When it drops, go to SWITCH if if_request=1, else to IDLE.
//  SWITCH: one bubble cycle with if_or_mem=00 and ram_wr=0, so the last in-flight read byte is
//   not misattributed; then go to IF if if_request=1, else to IDLE.
//  if_or_mem reflects the registered owner_q; there is no combinational grant.
//  The bus path is combinational from the owner:
//   IF owner:  ram_a=if_addr,  ram_wr=0.
//   MEM owner: ram_a=mem_addr, ram_wr=(mem_request==10), ram_dout=mem_data_i.
//   IDLE or SWITCH: ram_a=0, ram_wr=0.
//  Read data: ram_din goes straight to both if_data_o and mem_data_o.
//   Each client owns its own latency: the address is presented in cycle N and the data is sampled at the end of N+1.
//  IO throttle: when MEM owns the bus, the request is a STORE, addr is in the IO window and
//   io_buffer_full=1, then force ram_wr=0. The owner stays MEM, so the MEM stage keeps stalling
//   and replays the byte. The write goes out in the first cycle where io_buffer_full=0.
//  if_stall_request = if_request && owner_q!=IF, combinational.
//  Simultaneous events:
//   IF dropping its request while MEM raises one: go to IDLE, then MEM on the next cycle.
//   Both requests dropping in the same cycle: go to IDLE.
//  Reset mid-transaction: owner_q goes to IDLE at the next edge and ram_wr=0 that same cycle.
//   A partially written word is left as-is; restart is the MEM stage's job.
//  mem_request==11 is illegal and is treated as 00.
// STRUCTURE
//  Shared defines header: `RstEnable, owner codes (`OwnNone 2'b00, `OwnIf 2'b01, `OwnMem 2'b10),
//   mem request codes (`MemNone, `MemLoad, `MemStore), `InstAddrBus.
//  One natural sub-module, mem_ctrl_arb: the owner FSM plus if_or_mem/if_stall_request.
//   The top level holds the bus mux and the IO-throttle logic.
// TESTING
//  1 IF alone: if_request=1, if_addr=0x100..0x103 on successive cycles, RAM preloaded with 0x13,0x00,0x00,0x00
//    -> if_or_mem=01 from the 2nd cycle; bytes appear on if_data_o one cycle after each address.
//  2 Contention: both request in the same cycle -> MEM wins (10); after a 4-byte LW ends,
//    one SWITCH cycle (00), then 01.
//  3 SW to 0x200 of 0xDEADBEEF over 4 cycles -> ram_wr=1 with ram_a 0x200..0x203 and
//    ram_dout EF,BE,AD,DE; a readback with LW returns 0xDEADBEEF.
//  4 IO store to 0x30000 with io_buffer_full=1 for 3 cycles -> ram_wr=0 for those cycles, owner stays 10;
//    ram_wr=1 in the cycle after full drops.
//  5 rst=1 asserted in the middle of an SW -> next cycle if_or_mem=00, ram_wr=0; a new IF request is granted 2 cycles after release.
//  6 MEM request during an IF burst -> IF keeps 01 until if_request drops, then IDLE, then 10.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the core-to-external-bus memory controller.
// Owner codes, MEM request codes and the owner FSM state type live here.
package mem_ctrl_pkg;

  localparam logic RST_ENABLE    = 1'b1;
  localparam int   INST_ADDR_BUS = 32;

  // Externally visible owner code reported on if_or_mem.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_MEM  = 2'b10
  } own_e;

  // Request code driven by the MEM stage; 2'b11 is illegal.
  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_req_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IF,
    ST_MEM,
    ST_SWITCH
  } owner_state_e;

  // The illegal code 2'b11 counts as no request.
  function automatic logic mem_req_valid(input logic [1:0] req);
    return (req == MEM_LOAD) || (req == MEM_STORE);
  endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Bus-ownership FSM: MEM beats IF from IDLE, no preemption, and a one-cycle
// SWITCH bubble when the bus passes from MEM to IF.
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         if_request,
  input  logic [1:0]   mem_request,
  output owner_state_e owner_q,
  output logic [1:0]   if_or_mem,
  output logic         if_stall_request
);

  owner_state_e owner_d;
  logic         mem_req;
  logic         in_reset;

  assign mem_req  = mem_req_valid(mem_request);
  assign in_reset = (rst == RST_ENABLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      owner_q <= ST_IDLE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    owner_d   = owner_q;
    if_or_mem = OWN_NONE;
    unique case (owner_q)
      ST_IDLE: begin
        if (mem_req) begin
          owner_d = ST_MEM;
        end else if (if_request) begin
          owner_d = ST_IF;
        end
      end
      ST_IF: begin
        if_or_mem = OWN_IF;
        if (!if_request) begin
          owner_d = ST_IDLE;
        end
      end
      ST_MEM: begin
        if_or_mem = OWN_MEM;
        if (!mem_req) begin
          owner_d = if_request ? ST_SWITCH : ST_IDLE;
        end
      end
      ST_SWITCH: begin
        // Bubble: the last MEM read byte is still on ram_din this cycle.
        owner_d = if_request ? ST_IF : ST_IDLE;
      end
      default: owner_d = ST_IDLE;
    endcase
  end

  assign if_stall_request = !in_reset && if_request && (owner_q != ST_IF);

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial port between the core (IF and MEM clients) and the 8-bit external
// RAM/IO bus: owner arbitration, combinational bus mux and IO store throttle.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = INST_ADDR_BUS,
  parameter int IO_SEL_HI = 17,
  parameter int IO_SEL_LO = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_request,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [7:0]        if_data_o,
  input  logic [1:0]        mem_request,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        mem_data_o,
  output logic [1:0]        if_or_mem,
  output logic              if_stall_request,
  input  logic              io_buffer_full,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  owner_state_e owner_q;
  logic         in_reset;
  logic         is_store;
  logic         in_io_window;
  logic         io_throttle;

  mem_ctrl_arb u_arb (
    .clk              (clk),
    .rst              (rst),
    .if_request       (if_request),
    .mem_request      (mem_request),
    .owner_q          (owner_q),
    .if_or_mem        (if_or_mem),
    .if_stall_request (if_stall_request)
  );

  assign in_reset     = (rst == RST_ENABLE);
  assign is_store     = (mem_request == MEM_STORE);
  assign in_io_window = &mem_addr[IO_SEL_HI:IO_SEL_LO];
  // A held-back IO store keeps MEM as owner; the MEM stage replays the byte.
  assign io_throttle  = is_store && in_io_window && io_buffer_full;

  // Reset also forces the bus quiet combinationally, so a store cut short by
  // reset never writes during the reset cycle itself.
  always_comb begin
    ram_a    = '0;
    ram_wr   = 1'b0;
    ram_dout = '0;
    if (!in_reset) begin
      unique case (owner_q)
        ST_IF: begin
          ram_a = if_addr;
        end
        ST_MEM: begin
          ram_a    = mem_addr;
          ram_dout = mem_data_i;
          ram_wr   = is_store && !io_throttle;
        end
        default: ;
      endcase
    end
  end

  // Read data is broadcast; each client knows which cycle its byte belongs to.
  assign if_data_o  = in_reset ? '0 : ram_din;
  assign mem_data_o = in_reset ? '0 : ram_din;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus sticky random traffic,
// all compared each cycle against a rule-level ownership model and a byte RAM model.
module tb_mem_ctrl;

  localparam int M_IDLE = 0, M_IF = 1, M_MEM = 2, M_SWITCH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_request;
  logic [31:0] if_addr;
  logic [7:0]  if_data_o;
  logic [1:0]  mem_request;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_i;
  logic [7:0]  mem_data_o;
  logic [1:0]  if_or_mem;
  logic        if_stall_request;
  logic        io_buffer_full;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  mem_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .if_request       (if_request),
    .if_addr          (if_addr),
    .if_data_o        (if_data_o),
    .mem_request      (mem_request),
    .mem_addr         (mem_addr),
    .mem_data_i       (mem_data_i),
    .mem_data_o       (mem_data_o),
    .if_or_mem        (if_or_mem),
    .if_stall_request (if_stall_request),
    .io_buffer_full   (io_buffer_full),
    .ram_din          (ram_din),
    .ram_dout         (ram_dout),
    .ram_a            (ram_a),
    .ram_wr           (ram_wr)
  );

  always #5 clk = ~clk;

  // External RAM driven by the DUT: synchronous read, data one cycle after address.
  logic [7:0] ram [0:4095];
  logic [7:0] rd_q = 8'h00;
  always @(posedge clk) begin
    rd_q <= ram[ram_a[11:0]];
    if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
  end
  assign ram_din = rd_q;

  // Reference model state.
  logic [7:0]  golden [0:4095];
  int          m_owner = M_IDLE;
  logic [7:0]  exp_rd  = 8'h00;
  logic [31:0] exp_a;
  logic        exp_wr;
  bit          chk_en  = 1'b0;

  logic [1:0]  obs_own;
  logic        obs_wr;
  logic [31:0] obs_a;
  logic [7:0]  obs_idata, obs_mdata;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic        act, io, mreq;
    logic [1:0]  e_own;
    logic [7:0]  e_dout;
    @(negedge clk);
    act    = !rst;
    io     = (mem_addr[17:16] == 2'b11);
    e_own  = (m_owner == M_IF) ? 2'b01 : (m_owner == M_MEM) ? 2'b10 : 2'b00;
    exp_a  = !act ? 32'h0 : (m_owner == M_IF) ? if_addr : (m_owner == M_MEM) ? mem_addr : 32'h0;
    exp_wr = act && (m_owner == M_MEM) && (mem_request == 2'b10) && !(io && io_buffer_full);
    e_dout = (act && m_owner == M_MEM) ? mem_data_i : 8'h00;
    obs_own = if_or_mem; obs_wr = ram_wr; obs_a = ram_a;
    obs_idata = if_data_o; obs_mdata = mem_data_o;
    if (chk_en) begin
      check("if_or_mem", {30'h0, if_or_mem}, {30'h0, e_own});
      check("stall", {31'h0, if_stall_request}, {31'h0, act && if_request && (m_owner != M_IF)});
      check("ram_a", ram_a, exp_a);
      check("ram_wr", {31'h0, ram_wr}, {31'h0, exp_wr});
      check("ram_dout", {24'h0, ram_dout}, {24'h0, e_dout});
      check("if_data", {24'h0, if_data_o}, {24'h0, act ? exp_rd : 8'h00});
      check("mem_data", {24'h0, mem_data_o}, {24'h0, act ? exp_rd : 8'h00});
    end
    @(posedge clk);
    exp_rd = golden[exp_a[11:0]];
    if (exp_wr) golden[exp_a[11:0]] = mem_data_i;
    mreq = (mem_request == 2'b01) || (mem_request == 2'b10);
    if (rst)                       m_owner = M_IDLE;
    else if (m_owner == M_IDLE)    m_owner = mreq ? M_MEM : (if_request ? M_IF : M_IDLE);
    else if (m_owner == M_IF)      m_owner = if_request ? M_IF : M_IDLE;
    else if (m_owner == M_MEM)     m_owner = mreq ? M_MEM : (if_request ? M_SWITCH : M_IDLE);
    else                           m_owner = if_request ? M_IF : M_IDLE;
    #1;
  endtask

  task automatic idle(input int n);
    if_request = 1'b0; mem_request = 2'b00; io_buffer_full = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // 4-byte MEM access from IDLE: one arbitration cycle, then consecutive bytes.
  task automatic mem_access(input logic [1:0] req, input logic [31:0] base,
                            input logic [31:0] wdata, output logic [31:0] rword);
    rword = 32'h0;
    mem_request = req; mem_addr = base; mem_data_i = wdata[7:0];
    step();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        mem_addr = base + i; mem_data_i = wdata[8*i +: 8];
      end else begin
        mem_request = 2'b00;
      end
      step();
      if (i > 0) rword[8*(i-1) +: 8] = obs_mdata;
    end
  endtask

  task automatic if_fetch(input logic [31:0] base, output logic [31:0] rword);
    rword = 32'h0;
    if_request = 1'b1; if_addr = base;
    step();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) if_addr = base + i;
      else       if_request = 1'b0;
      step();
      if (i > 0) rword[8*(i-1) +: 8] = obs_idata;
    end
  endtask

  logic [31:0] word;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'(i * 37 + 5);
      golden[i] = ram[i];
    end
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h00; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    for (int i = 0; i < 4; i++) golden[12'h100 + i] = ram[12'h100 + i];

    rst = 1'b1; if_request = 1'b0; if_addr = 32'h0; mem_request = 2'b00;
    mem_addr = 32'h0; mem_data_i = 8'h00; io_buffer_full = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    idle(2);

    // IF alone: fetch 0x100..0x103.
    if_fetch(32'h100, word);
    check("if_word", word, 32'h0000_0013);
    idle(1);

    // Store then load back.
    mem_access(2'b10, 32'h200, 32'hDEAD_BEEF, word);
    idle(1);
    mem_access(2'b01, 32'h200, 32'h0, word);
    check("lw_readback", word, 32'hDEAD_BEEF);
    idle(1);

    // Contention: MEM wins, then SWITCH bubble, then IF.
    if_request = 1'b1; if_addr = 32'h180; mem_request = 2'b01; mem_addr = 32'h200;
    step();
    check("cont_first", {30'h0, obs_own}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      mem_addr = 32'h200 + i; step();
      check("cont_mem", {30'h0, obs_own}, 32'h2);
    end
    mem_request = 2'b00;
    step();
    step(); check("cont_switch", {30'h0, obs_own}, 32'h0);
    step(); check("cont_if", {30'h0, obs_own}, 32'h1);
    idle(2);

    // IO store throttled by io_buffer_full.
    mem_request = 2'b10; mem_addr = 32'h0003_0000; mem_data_i = 8'h5A; io_buffer_full = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("io_full_own", {30'h0, obs_own}, 32'h2);
      check("io_full_wr", {31'h0, obs_wr}, 32'h0);
    end
    io_buffer_full = 1'b0;
    step();
    check("io_go_wr", {31'h0, obs_wr}, 32'h1);
    check("io_go_a", obs_a, 32'h0003_0000);
    idle(2);

    // Reset in the middle of a store.
    mem_request = 2'b10; mem_addr = 32'h300; mem_data_i = 8'h11;
    step(); step();
    mem_addr = 32'h301; mem_data_i = 8'h22; step();
    rst = 1'b1; step();
    check("rst_cycle_wr", {31'h0, obs_wr}, 32'h0);
    rst = 1'b0; mem_request = 2'b00; if_request = 1'b1; if_addr = 32'h400;
    step();
    check("rst_owner", {30'h0, obs_own}, 32'h0);
    check("rst_wr", {31'h0, obs_wr}, 32'h0);
    step();
    check("rst_regrant", {30'h0, obs_own}, 32'h1);
    idle(2);

    // MEM request during an IF burst waits for IF to finish.
    if_request = 1'b1; if_addr = 32'h100;
    step(); step();
    mem_request = 2'b01; mem_addr = 32'h10;
    step(); check("nopre_if0", {30'h0, obs_own}, 32'h1);
    step(); check("nopre_if1", {30'h0, obs_own}, 32'h1);
    if_request = 1'b0;
    step(); check("nopre_last", {30'h0, obs_own}, 32'h1);
    step(); check("nopre_idle", {30'h0, obs_own}, 32'h0);
    step(); check("nopre_mem", {30'h0, obs_own}, 32'h2);
    idle(2);

    // Random sticky traffic, including the illegal code 2'b11 and rare resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) if_request = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) mem_request = 2'($urandom_range(0, 3));
      if_addr = 32'($urandom_range(0, 4095));
      mem_addr = ($urandom_range(0, 3) == 0) ? (32'h0003_0000 | 32'($urandom_range(0, 255)))
                                             : 32'($urandom_range(0, 4095));
      mem_data_i = 8'($urandom);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
